// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Circular FIFO capturing 4-bit ALU results together with the 2-bit op
//   select that produced them. The head entry is presented first-word-
//   fall-through. Dropped writes and empty reads raise sticky error flags.
//
// Parameters
//   DEPTH      number of entries, power of two >= 2
// Ports
//   Clk        clock, all state changes on the rising edge
//   Rst        synchronous active-high reset
//   FA..FAD    result bits to capture, FA is the MSB
//   S0, S1     op select captured as the entry tag
//   WrEn       capture request
//   RdEn       pop request for the head entry
//   ClrErr     clears Overflow/Underflow
//   DOut       head result {FA,FB,FC,FAD}, zero while empty
//   OpOut      head tag {S0,S1}, zero while empty
//   Count      stored entries, 0..DEPTH
//   Empty      Count == 0
//   Full       Count == DEPTH
//   Overflow   sticky: write dropped because FIFO was full
//   Underflow  sticky: read requested while FIFO was empty
module alu_result_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       FA,
   input  logic                       FB,
   input  logic                       FC,
   input  logic                       FAD,
   input  logic                       S0,
   input  logic                       S1,
   input  logic                       WrEn,
   input  logic                       RdEn,
   input  logic                       ClrErr,
   output logic [3:0]                 DOut,
   output logic [1:0]                 OpOut,
   output logic [$clog2(DEPTH):0]     Count,
   output logic                       Empty,
   output logic                       Full,
   output logic                       Overflow,
   output logic                       Underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [3:0]    data_mem [DEPTH];
   logic [1:0]    tag_mem  [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;

   logic wr_accept;
   logic rd_accept;
   logic ovf_event;
   logic udf_event;

   // Flags come from the registered count only, so no input reaches them
   // combinationally.
   assign Empty = (count_q == '0);
   assign Full  = (count_q == FULL_COUNT);
   assign Count = count_q;

   // A full FIFO still accepts a write when the head is popped in the same
   // cycle; an empty FIFO never accepts a read, even alongside a write.
   assign wr_accept = WrEn && (!Full || RdEn);
   assign rd_accept = RdEn && !Empty;
   assign ovf_event = WrEn && !RdEn && Full;
   assign udf_event = RdEn && Empty;

   // NOTE: the storage array has no reset; pointers and count define what is
   // valid, so stale contents are never visible and the array maps to RAM.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (wr_accept && !Rst) begin
         data_mem[wr_ptr] <= {FA, FB, FC, FAD};
         tag_mem[wr_ptr]  <= {S0, S1};
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
         if (rd_accept) rd_ptr <= rd_ptr + 1'b1;

         case ({wr_accept, rd_accept})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         // A clear loses to an error raised in the same cycle.
         if (ClrErr) begin
            Overflow  <= ovf_event;
            Underflow <= udf_event;
         end else begin
            Overflow  <= Overflow  | ovf_event;
            Underflow <= Underflow | udf_event;
         end
      end
   end

   // First-word-fall-through head, forced to zero while empty.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      DOut  = '0;
      OpOut = '0;
      if (!Empty) begin
         DOut  = data_mem[rd_ptr];
         OpOut = tag_mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo
//   Directed bench for alu_result_fifo (DEPTH=4): reset state, FWFT latency,
//   fill/overflow/drain ordering, simultaneous read+write at full and empty,
//   sticky flag clearing, pointer wrap, and reset during operation.
module tb_alu_result_fifo;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       FA, FB, FC, FAD, S0, S1;
   logic       WrEn, RdEn, ClrErr;
   logic [3:0] DOut;
   logic [1:0] OpOut;
   logic [2:0] Count;
   logic       Empty, Full, Overflow, Underflow;

   int n_assert = 0;
   int n_fail   = 0;

   alu_result_fifo #(.DEPTH(4)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .FA        (FA),
      .FB        (FB),
      .FC        (FC),
      .FAD       (FAD),
      .S0        (S0),
      .S1        (S1),
      .WrEn      (WrEn),
      .RdEn      (RdEn),
      .ClrErr    (ClrErr),
      .DOut      (DOut),
      .OpOut     (OpOut),
      .Count     (Count),
      .Empty     (Empty),
      .Full      (Full),
      .Overflow  (Overflow),
      .Underflow (Underflow)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given controls; controls return to idle 1 ns after
   // the edge, which is also where outputs are sampled.
   task automatic step(input logic wr, input logic rd, input logic clr, input logic rst,
                       input logic [3:0] d, input logic [1:0] t);
      WrEn = wr;
      RdEn = rd;
      ClrErr = clr;
      Rst = rst;
      {FA, FB, FC, FAD} = d;
      S0 = t[1];
      S1 = t[0];
      @(posedge Clk);
      #1;
      WrEn = 1'b0;
      RdEn = 1'b0;
      ClrErr = 1'b0;
      Rst = 1'b0;
   endtask

   task automatic wr(input logic [3:0] d, input logic [1:0] t);
      step(1'b1, 1'b0, 1'b0, 1'b0, d, t);
   endtask

   task automatic rd();
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'b00);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] v;
      Rst = 1'b1; WrEn = 1'b0; RdEn = 1'b0; ClrErr = 1'b0;
      {FA, FB, FC, FAD, S0, S1} = '0;

      // Reset state
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'b00);
      check("rst_count", Count, 0);
      check("rst_empty", Empty, 1);
      check("rst_full", Full, 0);
      check("rst_ovf", Overflow, 0);
      check("rst_udf", Underflow, 0);
      check("rst_dout", DOut, 0);
      check("rst_opout", OpOut, 0);

      // Single write into empty FIFO: visible one cycle later
      wr(4'b1011, 2'b10);
      check("w1_dout", DOut, 4'b1011);
      check("w1_opout", OpOut, 2'b10);
      check("w1_count", Count, 1);
      check("w1_empty", Empty, 0);
      rd();
      check("w1_drain_empty", Empty, 1);
      check("w1_drain_dout", DOut, 0);

      // Fill to DEPTH, then overflow
      wr(4'b0001, 2'b00);
      wr(4'b0010, 2'b01);
      wr(4'b0011, 2'b10);
      wr(4'b0100, 2'b11);
      check("fill_full", Full, 1);
      check("fill_count", Count, 4);
      check("fill_ovf_clear", Overflow, 0);
      wr(4'b0101, 2'b00);
      check("ovf_set", Overflow, 1);
      check("ovf_count", Count, 4);
      check("ovf_head", DOut, 4'b0001);
      check("ovf_head_tag", OpOut, 2'b00);

      // Drain in order
      for (int i = 1; i <= 4; i++) begin
         check("drain_dout", DOut, i);
         check("drain_tag", OpOut, i - 1);
         rd();
      end
      check("drain_empty", Empty, 1);
      check("drain_dout0", DOut, 0);
      check("drain_ovf_sticky", Overflow, 1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'b00);
      check("ovf_cleared", Overflow, 0);

      // Full with simultaneous write+read
      for (int i = 1; i <= 4; i++) begin
         v = 4'(i);
         wr(v, 2'b00);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 2'b11);
      check("fullwr_count", Count, 4);
      check("fullwr_full", Full, 1);
      check("fullwr_head", DOut, 4'b0010);
      check("fullwr_ovf", Overflow, 0);
      check("fullwr_q0", DOut, 4'b0010); rd();
      check("fullwr_q1", DOut, 4'b0011); rd();
      check("fullwr_q2", DOut, 4'b0100); rd();
      check("fullwr_q3", DOut, 4'b1111);
      check("fullwr_q3_tag", OpOut, 2'b11); rd();
      check("fullwr_empty", Empty, 1);

      // Underflow, clear, and clear racing a new underflow
      rd();
      check("udf_set", Underflow, 1);
      check("udf_count", Count, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'b00);
      check("udf_cleared", Underflow, 0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 2'b00);
      check("udf_clr_race", Underflow, 1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'b00);

      // Empty with simultaneous write+read: write wins, read flagged
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0111, 2'b01);
      check("emptywr_count", Count, 1);
      check("emptywr_udf", Underflow, 1);
      check("emptywr_dout", DOut, 4'b0111);
      check("emptywr_tag", OpOut, 2'b01);
      rd();
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'b00);

      // Ten alternating write/read pairs wrap both pointers
      for (int i = 0; i < 10; i++) begin
         v = 4'((i * 3 + 1) & 15);
         wr(v, 2'(i));
         check("alt_dout", DOut, v);
         check("alt_tag", OpOut, i & 3);
         check("alt_count1", Count, 1);
         rd();
         check("alt_count0", Count, 0);
      end

      // Reset mid-operation discards entries and wins over a write
      wr(4'b1000, 2'b00);
      wr(4'b1001, 2'b00);
      wr(4'b1010, 2'b00);
      wr(4'b1011, 2'b00);
      wr(4'b1100, 2'b00);
      check("pre_rst_ovf", Overflow, 1);
      rd();
      check("pre_rst_count", Count, 3);
      step(1'b1, 1'b0, 1'b0, 1'b1, 4'b1101, 2'b11);
      check("midrst_count", Count, 0);
      check("midrst_empty", Empty, 1);
      check("midrst_dout", DOut, 0);
      check("midrst_ovf", Overflow, 0);
      wr(4'b0110, 2'b01);
      check("postrst_dout", DOut, 4'b0110);
      check("postrst_tag", OpOut, 2'b01);
      check("postrst_count", Count, 1);
      rd();
      check("postrst_empty", Empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter DEPTH, 4, number of result entries; SHALL be a power of two >= 2.
REQ-002 Port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port Rst  input  1  reset, synchronous and active-high.
REQ-004 Ports FA, FB, FC, FAD  input  1 each  ALU result bits; FA is MSB, FAD is LSB.
REQ-005 Ports S0, S1  input  1 each  ALU op select in use for this result, stored as a tag.
REQ-006 Port WrEn  input  1  capture request for the current {FA,FB,FC,FAD,S0,S1}.
REQ-007 Port RdEn  input  1  pop request for the head entry.
REQ-008 Port ClrErr  input  1  clears sticky error flags.
REQ-009 Port DOut  output  4  head result; DOut[3]=FA ... DOut[0]=FAD.
REQ-010 Port OpOut  output  2  head tag; OpOut[1]=S0, OpOut[0]=S1.
REQ-011 Port Count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-012 Ports Empty, Full  output  1 each  Count==0 and Count==DEPTH respectively.
REQ-013 Ports Overflow, Underflow  output  1 each  sticky error flags.

Function
REQ-014 Block SHALL buffer ALU results as a circular FIFO, write and read pointers wrapping modulo DEPTH.
REQ-015 Accepted write: WrEn=1 and (Full=0 or RdEn=1); entry {result,tag} SHALL be stored at write pointer and pointer incremented.
REQ-016 Accepted read: RdEn=1 and Empty=0; read pointer SHALL increment.
REQ-017 Output SHALL be first-word-fall-through: DOut/OpOut show the head entry combinationally from storage whenever Empty=0.
REQ-018 DOut and OpOut SHALL be all zeros while Empty=1.
REQ-019 Write into an empty FIFO SHALL appear on DOut/OpOut in the cycle after the capturing edge (latency 1).
REQ-020 Count SHALL update on the same edge: +1 write only, -1 read only, unchanged for both or neither.
REQ-021 Full with WrEn=1 and RdEn=1: both accepted; Count stays DEPTH; Overflow not set.
REQ-022 Empty with WrEn=1 and RdEn=1: write accepted, read ignored, Count becomes 1, Underflow set.
REQ-023 WrEn=1, RdEn=0, Full=1: write dropped, storage and pointers unchanged, Overflow set to 1.
REQ-024 RdEn=1, Empty=1: no state change except Underflow set to 1.
REQ-025 Overflow and Underflow SHALL hold 1 until ClrErr=1 or Rst=1.
REQ-026 ClrErr=1 SHALL clear both flags on the next edge, unless a new error occurs that same cycle, in which case that flag SHALL be 1.
REQ-027 Empty, Full, Count SHALL derive from registered state only; no combinational path from WrEn/RdEn to them.

Reset
REQ-028 Rst=1 at an edge SHALL set both pointers 0, Count 0, Empty 1, Full 0, Overflow 0, Underflow 0; DOut/OpOut read 0.
REQ-029 Rst SHALL take priority over WrEn, RdEn, ClrErr in the same cycle; storage contents need not be cleared.
REQ-030 Rst asserted mid-operation SHALL discard all stored entries; the first post-reset write SHALL be the only visible entry.

Verification
REQ-031 Reset, write result 4'b1011 tag S0=1,S1=0 -> next cycle DOut=4'b1011, OpOut=2'b10, Count=1, Empty=0.
REQ-032 Write 0001,0010,0011,0100 (DEPTH=4) -> Full=1, Count=4; fifth write with RdEn=0 -> Overflow=1, four reads return 0001..0100 in order, then Empty=1, DOut=0.
REQ-033 Full FIFO, WrEn=RdEn=1 with 1111 -> Count stays 4, head advances to 0010, 1111 read last; Overflow stays 0.
REQ-034 Empty FIFO, RdEn=1 -> Underflow=1, Count=0; then ClrErr=1 -> Underflow=0; ClrErr=1 with RdEn=1 on empty -> Underflow remains 1.
REQ-035 Ten alternating write/read pairs -> pointers wrap, each read returns the value written, Count never exceeds 1.
REQ-036 Three entries stored, Rst=1 with WrEn=1 -> Count=0, Empty=1, write ignored; next write 0110 -> DOut=0110, Count=1.
